// File: rtl/mod_pkg.sv
// Shared defaults and FSM encoding for the modular accumulator.
package mod_pkg;

    localparam int DEF_FIELD_WIDTH = 16;
    localparam int DEF_COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mod_add.sv
// Combinational modular adder: y = (a + b) mod s, valid for a, b < s.
module mod_add #(
    parameter int FIELD_WIDTH = 16
) (
    input  logic [FIELD_WIDTH-1:0] a,
    input  logic [FIELD_WIDTH-1:0] b,
    input  logic [FIELD_WIDTH-1:0] s,
    output logic [FIELD_WIDTH-1:0] y
);

    logic [FIELD_WIDTH:0] sum_wide;
    logic [FIELD_WIDTH:0] s_ext;

    // One carry bit of headroom so a+b < 2s never wraps before the subtract.
    always_comb begin
        s_ext    = {1'b0, s};
        sum_wide = {1'b0, a} + {1'b0, b};
        if (sum_wide >= s_ext) begin
            y = FIELD_WIDTH'(sum_wide - s_ext);
        end else begin
            y = FIELD_WIDTH'(sum_wide);
        end
    end

endmodule

// File: rtl/mod_acc.sv
// Modular accumulator: sums len product terms (each in [0, 2s)) modulo s.
module mod_acc
    import mod_pkg::*;
#(
    parameter int FIELD_WIDTH = DEF_FIELD_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FIELD_WIDTH-1:0] s,
    input  logic [COUNT_WIDTH-1:0] len,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [FIELD_WIDTH:0]   in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [FIELD_WIDTH-1:0] out_data,
    input  logic                   out_ready,
    output logic                   busy
);

    state_e                 state_q, state_d;
    logic [FIELD_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [FIELD_WIDTH-1:0] s_q, s_d;
    logic [COUNT_WIDTH-1:0] len_q, len_d;

    logic [FIELD_WIDTH:0]   s_ext;
    logic [FIELD_WIDTH-1:0] term_red;
    logic [FIELD_WIDTH-1:0] acc_sum;
    logic [COUNT_WIDTH-1:0] cnt_inc;

    // Bring the incoming product from [0, 2s) down to [0, s) before adding.
    always_comb begin
        s_ext = {1'b0, s_q};
        if (in_data >= s_ext) begin
            term_red = FIELD_WIDTH'(in_data - s_ext);
        end else begin
            term_red = FIELD_WIDTH'(in_data);
        end
    end

    mod_add #(
        .FIELD_WIDTH(FIELD_WIDTH)
    ) u_add (
        .a(acc_q),
        .b(term_red),
        .s(s_q),
        .y(acc_sum)
    );

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        len_d   = len_q;
        cnt_inc = cnt_q + COUNT_WIDTH'(1);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = s;
                    len_d   = len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (len != '0) ? ST_ACC : ST_DONE;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Modulus and length are only meaningful once a start has loaded them.
    always_ff @(posedge clk) begin
        s_q   <= s_d;
        len_q <= len_d;
    end

    // Outputs decode straight from registered state, so in_ready never sees in_valid.
    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        out_data  = acc_q;
    end

endmodule
